// File: rtl/reduce_tree_pipe_if.sv
// Handshake bundle for reduce_tree_pipe: input vector/operator channel and 1-bit result channel.
// REDUCE_TREE_PIPE_COUNT_EN adds the out_count result-handshake counter to the bundle.
interface reduce_tree_pipe_if #(
  parameter int WIDTH = 16
) ();
  localparam int LEVELS = $clog2(WIDTH);

  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_data;
  logic [2*LEVELS-1:0]   in_op;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_b;
`ifdef REDUCE_TREE_PIPE_COUNT_EN
  logic [31:0]           out_count;

  modport master (
    output in_valid, in_data, in_op, out_ready,
    input  in_ready, out_valid, out_b, out_count
  );

  modport slave (
    input  in_valid, in_data, in_op, out_ready,
    output in_ready, out_valid, out_b, out_count
  );
`else
  modport master (
    output in_valid, in_data, in_op, out_ready,
    input  in_ready, out_valid, out_b
  );

  modport slave (
    input  in_valid, in_data, in_op, out_ready,
    output in_ready, out_valid, out_b
  );
`endif
endinterface

// File: rtl/reduce_tree_pipe.sv
// Pipelined binary reduction tree: WIDTH bits -> 1 bit, per-level AND/OR/XOR/XNOR, one stage per level.
// Optional REDUCE_TREE_PIPE_COUNT_EN: adds a wrapping 32-bit count of accepted results.
module reduce_tree_pipe #(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  reduce_tree_pipe_if.slave bus
);
  localparam int LEVELS = $clog2(WIDTH);
  localparam int HALF   = WIDTH / 2;
  localparam int OPW    = 2 * LEVELS;

  // Upper half OP lower half of a w-bit vector; bits above w/2 are forced to zero.
  function automatic logic [HALF-1:0] f_level(input logic [WIDTH-1:0] v, input int w,
                                              input logic [1:0] op);
    logic [HALF-1:0] lo;
    logic [HALF-1:0] hi;
    logic [HALF-1:0] mask;
    logic [HALF-1:0] res;
    lo   = v[HALF-1:0];
    hi   = HALF'(v >> (w / 2));
    mask = {HALF{1'b1}} >> (HALF - (w / 2));
    case (op)
      2'b00:   res = hi & lo;
      2'b01:   res = hi | lo;
      2'b10:   res = hi ^ lo;
      2'b11:   res = ~(hi ^ lo);
      default: res = {HALF{1'b0}};
    endcase
    return res & mask;
  endfunction

  logic [LEVELS:1]  r_vld;
  logic [HALF-1:0]  r_data [1:LEVELS];
  logic [OPW-1:0]   r_op   [1:LEVELS];

  logic [LEVELS:1]  w_en;
  logic [LEVELS:1]  w_up_vld;
  logic [WIDTH-1:0] w_src    [1:LEVELS];
  logic [OPW-1:0]   w_src_op [1:LEVELS];
  logic [HALF-1:0]  w_res    [1:LEVELS];
  logic             w_any_empty;
  logic             w_unused_op;

  // Upstream view of each stage: stage 1 sees the input port, stage k sees stage k-1.
  always_comb begin
    w_up_vld[1] = bus.in_valid;
    w_src[1]    = bus.in_data;
    w_src_op[1] = bus.in_op;
    for (int k = 2; k <= LEVELS; k++) begin
      w_up_vld[k] = r_vld[k-1];
      w_src[k]    = WIDTH'(r_data[k-1]);
      w_src_op[k] = r_op[k-1];
    end
  end

  // Level k consumes the low operator field; the rest shifts down as the data advances.
  always_comb begin
    for (int k = 1; k <= LEVELS; k++) begin
      w_res[k] = f_level(w_src[k], WIDTH >> (k - 1), w_src_op[k][1:0]);
    end
  end

  // A stage may load when it or any stage after it is empty, or the consumer is ready.
  always_comb begin
    w_any_empty = 1'b0;
    for (int k = 1; k <= LEVELS; k++) begin
      w_any_empty = 1'b0;
      for (int j = k; j <= LEVELS; j++) begin
        w_any_empty = w_any_empty | ~r_vld[j];
      end
      w_en[k] = bus.out_ready | w_any_empty;
    end
  end

  // Stage registers; a disabled stage holds, an enabled one takes its level result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      for (int k = 1; k <= LEVELS; k++) begin
        r_data[k] <= '0;
        r_op[k]   <= '0;
      end
    end else begin
      for (int k = 1; k <= LEVELS; k++) begin
        if (w_en[k]) begin
          r_vld[k]  <= w_up_vld[k];
          r_data[k] <= w_res[k];
          r_op[k]   <= w_src_op[k] >> 2;
        end
      end
    end
  end

  assign w_unused_op   = ^r_op[LEVELS];
  assign bus.in_ready  = w_en[1];
  assign bus.out_valid = r_vld[LEVELS];
  // Only bit 0 of the last stage can be set, so the OR is exactly that bit.
  assign bus.out_b     = |r_data[LEVELS];

`ifdef REDUCE_TREE_PIPE_COUNT_EN
  logic [31:0] r_count;

  // Counts completed result handshakes, wrapping naturally at 32 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 32'd0;
    end else if (r_vld[LEVELS] && bus.out_ready) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign bus.out_count = r_count;
`endif
endmodule

// File: tb/tb_reduce_tree_pipe.sv
// Directed self-checking bench for reduce_tree_pipe (WIDTH=16 and WIDTH=2 instances).
module tb_reduce_tree_pipe;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  reduce_tree_pipe_if #(.WIDTH(16)) bus16 ();
  reduce_tree_pipe_if #(.WIDTH(2))  bus2 ();

  reduce_tree_pipe #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));
  reduce_tree_pipe #(.WIDTH(2))  u_dut2  (.clk(clk), .rst(rst), .bus(bus2));

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // Reference reduction for WIDTH=16, level by level.
  function automatic logic model16(input logic [15:0] d, input logic [7:0] op);
    logic [15:0] v;
    logic [15:0] nv;
    logic [1:0]  o;
    logic        a;
    logic        b;
    int          w;
    v = d;
    w = 16;
    for (int lvl = 0; lvl < 4; lvl++) begin
      o  = op[2*lvl +: 2];
      nv = 16'h0000;
      for (int i = 0; i < w / 2; i++) begin
        a = v[i + w/2];
        b = v[i];
        case (o)
          2'b00:   nv[i] = a & b;
          2'b01:   nv[i] = a | b;
          2'b10:   nv[i] = a ^ b;
          default: nv[i] = ~(a ^ b);
        endcase
      end
      v = nv;
      w = w / 2;
    end
    return v[0];
  endfunction

  // One isolated transaction on the 16-bit tree with out_ready held high.
  task automatic run16(input string tag, input logic [15:0] d, input logic [7:0] op,
                       input logic exp);
    int n;
    @(negedge clk);
    bus16.in_valid = 1'b1;
    bus16.in_data  = d;
    bus16.in_op    = op;
    #1;
    chk_eq({tag, "_rdy"}, bus16.in_ready, 1);
    @(negedge clk);
    bus16.in_valid = 1'b0;
    n = 1;
    while (!bus16.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk_eq({tag, "_lat"}, n, 4);
    chk_eq({tag, "_b"}, bus16.out_b, exp);
    @(negedge clk);
    chk_eq({tag, "_once"}, bus16.out_valid, 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout, want finish (total=%0d bad=%0d)", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        exp_q [$];
    logic [15:0] bp_d  [6];
    logic        bp_e  [6];
    int          acc;
    int          got;
    int          seen;
    logic        pend;
    logic        rdy;

    rst = 1'b1;
    bus16.in_valid = 1'b0; bus16.in_data = 16'h0000; bus16.in_op = 8'h00; bus16.out_ready = 1'b1;
    bus2.in_valid  = 1'b0; bus2.in_data  = 2'b00;    bus2.in_op  = 2'b00; bus2.out_ready  = 1'b1;
    #12 rst = 1'b0;

    @(negedge clk);
    chk_eq("rst_vld16", bus16.out_valid, 0);
    chk_eq("rst_b16",   bus16.out_b,     0);
    chk_eq("rst_rdy16", bus16.in_ready,  1);
    chk_eq("rst_vld2",  bus2.out_valid,  0);
    chk_eq("rst_rdy2",  bus2.in_ready,   1);

    // mixed operators, all-XOR parity, all-AND, all-XNOR, all-OR
    run16("t1_ffff", 16'hFFFF, 8'h98, 1'b0);
    run16("t1_0101", 16'h0101, 8'h98, 1'b1);
    run16("par_0001", 16'h0001, 8'hAA, 1'b1);
    run16("par_0003", 16'h0003, 8'hAA, 1'b0);
    run16("par_8000", 16'h8000, 8'hAA, 1'b1);
    run16("and_ffff", 16'hFFFF, 8'h00, 1'b1);
    run16("and_fffe", 16'hFFFE, 8'h00, 1'b0);
    run16("xnor_0000", 16'h0000, 8'hFF, 1'b1);
    run16("or_0400", 16'h0400, 8'h55, 1'b1);
    run16("or_0000", 16'h0000, 8'h55, 1'b0);

    // full back-to-back sweep
    for (int i = 0; i < 65536 + 6; i++) begin
      @(negedge clk);
      if (i >= 4 && i < 65540) chk_eq("s_vld", bus16.out_valid, 1);
      if (bus16.out_valid) begin
        if (exp_q.size() == 0) chk_eq("s_extra", bus16.out_valid, 0);
        else chk_eq("s_b", bus16.out_b, exp_q.pop_front());
      end
      if (i < 65536) begin
        bus16.in_valid = 1'b1;
        bus16.in_data  = i[15:0];
        bus16.in_op    = 8'h98;
        exp_q.push_back(model16(i[15:0], 8'h98));
      end else begin
        bus16.in_valid = 1'b0;
      end
    end
    chk_eq("s_left", exp_q.size(), 0);

    // backpressure: stall for 8 cycles with 6 inputs pending, then drain
    bp_d[0] = 16'h0001; bp_e[0] = 1'b1;
    bp_d[1] = 16'h8000; bp_e[1] = 1'b1;
    bp_d[2] = 16'h0003; bp_e[2] = 1'b0;
    bp_d[3] = 16'h0700; bp_e[3] = 1'b1;
    bp_d[4] = 16'hFFFF; bp_e[4] = 1'b0;
    bp_d[5] = 16'h0000; bp_e[5] = 1'b0;
    acc = 0; got = 0; pend = 1'b0; rdy = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (pend && rdy) acc++;
      bus16.out_ready = (c >= 8);
      if (bus16.out_valid) begin
        if (bus16.out_ready) begin
          if (got < 6) chk_eq($sformatf("bp_b%0d", got), bus16.out_b, bp_e[got]);
          else chk_eq("bp_dup", bus16.out_valid, 0);
          got++;
        end else begin
          chk_eq("bp_hold", bus16.out_b, bp_e[0]);
        end
      end
      if (c == 7) begin
        chk_eq("bp_acc4", acc, 4);
        chk_eq("bp_vld", bus16.out_valid, 1);
      end
      bus16.in_valid = (acc < 6);
      bus16.in_op    = 8'hAA;
      if (acc < 6) bus16.in_data = bp_d[acc];
      #1;
      rdy  = bus16.in_ready;
      pend = bus16.in_valid;
      if (c < 8) chk_eq($sformatf("bp_rdy%0d", c), rdy, (c < 4));
    end
    chk_eq("bp_got", got, 6);
    chk_eq("bp_acc6", acc, 6);

    // reset with three transactions in flight
    bus16.out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus16.in_valid = (c < 3);
      bus16.in_data  = 16'h0001;
      bus16.in_op    = 8'hAA;
    end
    @(negedge clk);
    chk_eq("rs_pre_vld", bus16.out_valid, 1);
    chk_eq("rs_pre_b",   bus16.out_b,     1);
    #2 rst = 1'b1;
    #1;
    chk_eq("rs_vld", bus16.out_valid, 0);
    chk_eq("rs_b",   bus16.out_b,     0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    bus16.out_ready = 1'b1;
    @(negedge clk);
    chk_eq("rs_rdy", bus16.in_ready, 1);
`ifdef REDUCE_TREE_PIPE_COUNT_EN
    chk_eq("rs_cnt", bus16.out_count, 0);
`endif
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus16.out_valid) seen++;
    end
    chk_eq("rs_ghost", seen, 0);

    // WIDTH=2: single stage, XOR
    @(negedge clk);
    bus2.in_valid = 1'b1; bus2.in_data = 2'b10; bus2.in_op = 2'b10;
    #1 chk_eq("w2_rdy", bus2.in_ready, 1);
    @(negedge clk);
    bus2.in_valid = 1'b0;
    chk_eq("w2_vld_a", bus2.out_valid, 1);
    chk_eq("w2_b_10",  bus2.out_b,     1);
    @(negedge clk);
    chk_eq("w2_once", bus2.out_valid, 0);
    bus2.in_valid = 1'b1; bus2.in_data = 2'b11;
    @(negedge clk);
    bus2.in_valid = 1'b0;
    chk_eq("w2_vld_b", bus2.out_valid, 1);
    chk_eq("w2_b_11",  bus2.out_b,     0);
    @(negedge clk);
`ifdef REDUCE_TREE_PIPE_COUNT_EN
    chk_eq("w2_cnt", bus2.out_count, 2);
`endif
    chk_eq("w2_idle", bus2.out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
